// File: rtl/cache_pkg.sv
// Shared types and default geometry for the instruction-cache refill path.
// Pure declarations: no logic, no latency, no flow control.
package cache_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned BEAT_WIDTH  = 64;
    localparam int unsigned BEATS       = BLOCK_BYTES / 8;
    localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        WAIT
    } refill_state_t;

endpackage

// File: rtl/refill_perf_counter.sv
// Saturating 32-bit event counter with increment enable.
// Latency: count reflects an increment on the edge after inc_i; no backpressure.
module refill_perf_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/instr_cache_refill_ctrl.sv
// Refills one I-cache block on a miss: latches the block address, requests it, streams beats into the set.
// Latency: 1 (REQ) + B/8 (FILL) + 1 (WAIT) cycles with ideal memory; each beat reaches RepEnable one cycle later.
// Backpressure: none on the read stream (all FILL beats taken); fetch stalled while busy. REFILL_PERF_CNT_EN adds counters.
module instr_cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned B      = BLOCK_BYTES,
    parameter int unsigned ADDR_W = ADDR_WIDTH,
    parameter int unsigned BEAT_W = BEAT_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              FetchValid,
    input  logic [ADDR_W-1:0] FetchAddr,
    input  logic              CacheMiss,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic              MemRValid,
    input  logic [BEAT_W-1:0] MemRData,
    output logic              RepEnable,
    output logic [BEAT_W-1:0] RepWord,
    output logic              RefillBusy,
    output logic              StallF
`ifdef REFILL_PERF_CNT_EN
    ,
    output logic [31:0]       MissCount,
    output logic [31:0]       StallCycles
`endif
);

    localparam int unsigned NBEATS = B / 8;
    localparam int unsigned CNT_W  = $clog2(NBEATS);
    localparam int unsigned OFF_W  = $clog2(B);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    refill_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rep_en_q, rep_en_d;
    logic [BEAT_W-1:0] rep_word_q, rep_word_d;
    logic              miss;
    logic              beat_acc;

    assign miss     = FetchValid && CacheMiss;
    assign beat_acc = (state_q == FILL) && MemRValid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rep_en_d   = beat_acc;
        rep_word_d = rep_word_q;

        if (beat_acc) begin
            rep_word_d = MemRData;
        end

        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = REQ;
                    addr_d  = {FetchAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end
            end
            REQ: begin
                if (MemAck) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // Counter wraps naturally back to 0 on the last beat.
                if (MemRValid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rep_en_q   <= 1'b0;
            rep_word_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rep_en_q   <= rep_en_d;
            rep_word_q <= rep_word_d;
        end
    end

    assign MemReq     = (state_q == REQ);
    assign MemAddr    = addr_q;
    assign RepEnable  = rep_en_q;
    assign RepWord    = rep_word_q;
    assign RefillBusy = (state_q != IDLE);
    assign StallF     = miss || RefillBusy;

`ifdef REFILL_PERF_CNT_EN
    refill_perf_counter u_miss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   ((state_q == IDLE) && miss),
        .count_o (MissCount)
    );

    refill_perf_counter u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (RefillBusy),
        .count_o (StallCycles)
    );
`endif

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Randomised bench for instr_cache_refill_ctrl against a cycle-count and beat-order reference model.
module tb_instr_cache_refill_ctrl;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        FetchValid = 1'b0;
    logic        CacheMiss = 1'b0;
    logic        MemAck = 1'b0;
    logic        MemRValid = 1'b0;
    logic [31:0] FetchAddr = 32'd0;
    logic [63:0] MemRData = 64'd0;
    logic        MemReq, RepEnable, RefillBusy, StallF;
    logic [31:0] MemAddr;
    logic [63:0] RepWord;
`ifdef REFILL_PERF_CNT_EN
    logic [31:0] MissCount, StallCycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] got_q[$];
    int busy_cnt = 0;
    int req_cnt = 0;
    int stall_cnt = 0;

    logic [63:0] exp_q[$];
    int          st_q0, st_busy, st_req, st_stall;
    logic [31:0] st_addr_req, st_addr_wait;

    instr_cache_refill_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .FetchValid (FetchValid),
        .FetchAddr  (FetchAddr),
        .CacheMiss  (CacheMiss),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemRValid  (MemRValid),
        .MemRData   (MemRData),
        .RepEnable  (RepEnable),
        .RepWord    (RepWord),
        .RefillBusy (RefillBusy),
        .StallF     (StallF)
`ifdef REFILL_PERF_CNT_EN
        ,
        .MissCount  (MissCount),
        .StallCycles(StallCycles)
`endif
    );

    always #5 clk = ~clk;

    // Observe strobes and busy/stall/request occupancy mid-cycle.
    always @(negedge clk) begin
        if (RepEnable === 1'b1) got_q.push_back(RepWord);
        if (RefillBusy === 1'b1) busy_cnt++;
        if (StallF === 1'b1) stall_cnt++;
        if (MemReq === 1'b1) req_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Refill occupancy: request cycles, one per beat plus gaps between beats, one settle cycle.
    function automatic int model_busy(input int ack_dly, input logic [BEATS-1:0] gaps);
        int n;
        n = ack_dly + 1 + int'(BEATS) + 1;
        for (int k = 0; k < int'(BEATS) - 1; k++) if (gaps[k]) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_block(input logic [31:0] a);
        return a & ~(BLOCK_BYTES - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a miss, answers the request after ack_dly cycles and streams one block.
    task automatic run_refill(input logic [31:0] addr, input int ack_dly, input logic [BEATS-1:0] gaps,
                              input bit junk_in_req, input bit hold_new);
        int b0, r0, s0;
        exp_q.delete();
        st_q0 = got_q.size();
        b0 = busy_cnt; r0 = req_cnt; s0 = stall_cnt;
        FetchValid = 1'b1; CacheMiss = 1'b1; FetchAddr = addr;
        tick();
        FetchValid = 1'b0; CacheMiss = 1'b0; FetchAddr = $urandom;
        st_addr_req = MemAddr;
        for (int i = 0; i <= ack_dly; i++) begin
            MemAck = (i == ack_dly);
            MemRValid = junk_in_req;
            MemRData = {$urandom, $urandom};
            tick();
        end
        MemAck = 1'b0;
        if (hold_new) begin
            FetchValid = 1'b1; CacheMiss = 1'b1; FetchAddr = 32'h0000_8000;
        end
        for (int k = 0; k < int'(BEATS); k++) begin
            MemRValid = 1'b1;
            MemRData = {$urandom, $urandom};
            exp_q.push_back(MemRData);
            tick();
            if (gaps[k] && k < int'(BEATS) - 1) begin
                MemRValid = 1'b0;
                MemRData = {$urandom, $urandom};
                tick();
            end
        end
        MemRValid = 1'b0;
        st_addr_wait = MemAddr;
        tick();
        st_busy = busy_cnt - b0;
        st_req = req_cnt - r0;
        st_stall = stall_cnt - s0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({MemReq, RepEnable, RefillBusy, StallF} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 0000", {MemReq, RepEnable, RefillBusy, StallF});
        end
        vectors++;
        if ({MemAddr, RepWord} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_data: MemAddr %h RepWord %h, expected zero", MemAddr, RepWord);
        end
        FetchValid = 1'b1; CacheMiss = 1'b1;
        #1;
        vectors++;
        if ({StallF, MemReq} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_comb_stall: StallF,MemReq %b, expected 10", {StallF, MemReq});
        end
        FetchValid = 1'b0; CacheMiss = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ideal_refill();
        run_refill(32'h0000_1234, 0, '0, 1'b0, 1'b0);
        vectors++;
        if (st_addr_req !== 32'h0000_1200) begin
            miscompares++;
            $display("FAIL ideal_memaddr: got %h, expected 00001200", st_addr_req);
        end
        vectors++;
        if (got_q.size() - st_q0 != int'(BEATS)) begin
            miscompares++;
            $display("FAIL ideal_strobes: got %0d, expected %0d", got_q.size() - st_q0, BEATS);
        end
        for (int i = 0; i < int'(BEATS); i++) begin
            vectors++;
            if (st_q0 + i >= got_q.size() || got_q[st_q0 + i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ideal_beat%0d: got %h, expected %h", i,
                         (st_q0 + i < got_q.size()) ? got_q[st_q0 + i] : 64'hx, exp_q[i]);
            end
        end
        vectors++;
        if (st_busy !== model_busy(0, '0) || st_req !== 1) begin
            miscompares++;
            $display("FAIL ideal_timing: busy %0d req %0d, expected busy %0d req 1", st_busy, st_req, model_busy(0, '0));
        end
        vectors++;
        if (st_stall !== 11 || StallF !== 1'b0 || RefillBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL ideal_stall: stall cycles %0d StallF %b busy %b, expected 11 0 0", st_stall, StallF, RefillBusy);
        end
    endtask

    task automatic test_slow_mem();
        logic [BEATS-1:0] gaps;
        gaps = '0;
        gaps[2] = 1'b1;
        gaps[5] = 1'b1;
        run_refill($urandom, 5, gaps, 1'b0, 1'b0);
        vectors++;
        if (st_req !== 6) begin
            miscompares++;
            $display("FAIL slow_req_held: got %0d cycles, expected 6", st_req);
        end
        vectors++;
        if (got_q.size() - st_q0 != int'(BEATS)) begin
            miscompares++;
            $display("FAIL slow_strobes: got %0d, expected %0d", got_q.size() - st_q0, BEATS);
        end
        for (int i = 0; i < int'(BEATS); i++) begin
            vectors++;
            if (st_q0 + i >= got_q.size() || got_q[st_q0 + i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL slow_beat%0d: got %h, expected %h", i,
                         (st_q0 + i < got_q.size()) ? got_q[st_q0 + i] : 64'hx, exp_q[i]);
            end
        end
        vectors++;
        if (st_busy !== model_busy(5, gaps)) begin
            miscompares++;
            $display("FAIL slow_busy: got %0d, expected %0d", st_busy, model_busy(5, gaps));
        end
    endtask

    task automatic test_addr_hold();
        run_refill(32'h0000_1234, 1, '0, 1'b0, 1'b1);
        vectors++;
        if (st_addr_wait !== 32'h0000_1200) begin
            miscompares++;
            $display("FAIL hold_memaddr: got %h, expected 00001200", st_addr_wait);
        end
        vectors++;
        if (st_busy !== model_busy(1, '0)) begin
            miscompares++;
            $display("FAIL hold_busy: got %0d, expected %0d", st_busy, model_busy(1, '0));
        end
        vectors++;
        if ({RefillBusy, MemReq, StallF} !== 3'b001) begin
            miscompares++;
            $display("FAIL hold_idle_gap: busy,req,stall %b, expected 001", {RefillBusy, MemReq, StallF});
        end
        run_refill(32'h0000_8000, 0, '0, 1'b0, 1'b0);
        vectors++;
        if (st_addr_req !== 32'h0000_8000 || got_q.size() - st_q0 != int'(BEATS)) begin
            miscompares++;
            $display("FAIL hold_next_miss: addr %h strobes %0d, expected 00008000 %0d",
                     st_addr_req, got_q.size() - st_q0, BEATS);
        end
    endtask

    task automatic test_stray_beats();
        int q0;
        q0 = got_q.size();
        for (int i = 0; i < 3; i++) begin
            MemRValid = 1'b1;
            MemRData = {$urandom, $urandom};
            tick();
        end
        MemRValid = 1'b0;
        tick();
        vectors++;
        if (got_q.size() != q0 || RefillBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_idle: strobes %0d busy %b, expected 0 0", got_q.size() - q0, RefillBusy);
        end
        run_refill($urandom, 2, '0, 1'b1, 1'b0);
        vectors++;
        if (got_q.size() - st_q0 != int'(BEATS) || st_busy !== model_busy(2, '0)) begin
            miscompares++;
            $display("FAIL stray_req: strobes %0d busy %0d, expected %0d %0d",
                     got_q.size() - st_q0, st_busy, BEATS, model_busy(2, '0));
        end
        for (int i = 0; i < int'(BEATS); i++) begin
            vectors++;
            if (st_q0 + i >= got_q.size() || got_q[st_q0 + i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stray_beat%0d: got %h, expected %h", i,
                         (st_q0 + i < got_q.size()) ? got_q[st_q0 + i] : 64'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int q0, b0;
        FetchValid = 1'b1; CacheMiss = 1'b1; FetchAddr = $urandom;
        tick();
        FetchValid = 1'b0; CacheMiss = 1'b0;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            MemRValid = 1'b1;
            MemRData = {$urandom, $urandom};
            tick();
        end
        MemRData = {$urandom, $urandom};
        reset_n = 1'b0;
        q0 = got_q.size();
        b0 = busy_cnt;
        tick();
        vectors++;
        if ({RefillBusy, RepEnable, MemReq} !== 3'b000) begin
            miscompares++;
            $display("FAIL rstfill_state: busy,rep,req %b, expected 000", {RefillBusy, RepEnable, MemReq});
        end
        reset_n = 1'b1;
        for (int k = 4; k < int'(BEATS); k++) begin
            MemRValid = 1'b1;
            MemRData = {$urandom, $urandom};
            tick();
        end
        MemRValid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (got_q.size() != q0 || busy_cnt != b0) begin
            miscompares++;
            $display("FAIL rstfill_later_beats: strobes %0d busy cycles %0d, expected 0 0",
                     got_q.size() - q0, busy_cnt - b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      addr;
        int               dly;
        logic [BEATS-1:0] gaps;
        for (int n = 0; n < 6; n++) begin
            addr = $urandom;
            dly = $urandom_range(0, 3);
            gaps = BEATS'($urandom);
            run_refill(addr, dly, gaps, 1'(n % 2), 1'b0);
            vectors++;
            if (st_addr_req !== model_block(addr) || st_req !== dly + 1) begin
                miscompares++;
                $display("FAIL b2b%0d_req: addr %h req %0d, expected %h %0d", n, st_addr_req, st_req, model_block(addr), dly + 1);
            end
            vectors++;
            if (st_busy !== model_busy(dly, gaps) || got_q.size() - st_q0 != int'(BEATS)) begin
                miscompares++;
                $display("FAIL b2b%0d_len: busy %0d strobes %0d, expected %0d %0d", n, st_busy,
                         got_q.size() - st_q0, model_busy(dly, gaps), BEATS);
            end
            for (int i = 0; i < int'(BEATS); i++) begin
                vectors++;
                if (st_q0 + i >= got_q.size() || got_q[st_q0 + i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL b2b%0d_beat%0d: got %h, expected %h", n, i,
                             (st_q0 + i < got_q.size()) ? got_q[st_q0 + i] : 64'hx, exp_q[i]);
                end
            end
        end
    endtask

`ifdef REFILL_PERF_CNT_EN
    task automatic test_perf_counters();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if (MissCount !== 32'd0 || StallCycles !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_reset: MissCount %0d StallCycles %0d, expected 0 0", MissCount, StallCycles);
        end
        run_refill($urandom, 0, '0, 1'b0, 1'b0);
        run_refill($urandom, 0, '0, 1'b0, 1'b0);
        vectors++;
        if (MissCount !== 32'd2 || StallCycles !== 32'd20) begin
            miscompares++;
            $display("FAIL perf_counts: MissCount %0d StallCycles %0d, expected 2 20", MissCount, StallCycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ideal_refill();
        test_slow_mem();
        test_addr_hold();
        test_stray_beats();
        test_reset_mid_fill();
        test_back_to_back();
`ifdef REFILL_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
